// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, types and helpers for the MIPS core
//
// Contents:
//   RESET_VECTOR      default program counter after reset
//   *_MSB / *_LSB     instruction field positions
//   ST_REQ/HOLD/DRAIN fetch FSM state encoding (2 bits)
//   ifid_t            {instruction, pc+4} pair held in IF/ID and the skid buffer
//   align_word()      clears the byte-offset bits of an address
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with a one-entry skid buffer
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            capture din into IF/ID, mark valid
//   park            capture din into the skid buffer
//   unpark          move the skid buffer into IF/ID
//   bubble          mark IF/ID empty, contents kept
//   flush           mark IF/ID empty and drop the skid buffer (highest priority)
//   din             incoming {instruction, pc+4}
//   id_valid        IF/ID holds a live instruction
//   id_instr/id_pc4 registered instruction and its pc+4
//   id_opcode..id_imm16  field slices of id_instr
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        park,
    input  logic        unpark,
    input  logic        bubble,
    input  logic        flush,
    input  ifid_t       din,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16
);

    ifid_t skid;
    logic  skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_instr   <= 32'h0;
            id_pc4     <= 32'h0;
            skid       <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (load) begin
                id_instr <= din.instr;
                id_pc4   <= din.pc4;
                id_valid <= 1'b1;
            end else if (unpark) begin
                id_instr   <= skid.instr;
                id_pc4     <= skid.pc4;
                id_valid   <= skid_valid;
                skid_valid <= 1'b0;
            end else if (bubble) begin
                id_valid <= 1'b0;
            end
            // park and unpark are never raised together by the fetch FSM
            if (park) begin
                skid       <= din;
                skid_valid <= 1'b1;
            end
        end
    end

    assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_rs     = id_instr[RS_MSB:RS_LSB];
    assign id_rt     = id_instr[RT_MSB:RT_LSB];
    assign id_rd     = id_instr[RD_MSB:RD_LSB];
    assign id_shamt  = id_instr[SHAMT_MSB:SHAMT_LSB];
    assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];
    assign id_imm16  = id_instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, imem handshake, IF/ID register
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (sticky misaligned-redirect flag)
//
// Parameters:
//   RESET_PC        PC and fetch address loaded on reset
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   imem_req        registered read request
//   imem_addr       registered word address, stable while a request is unacked
//   imem_ack        read data valid, ends the request
//   imem_rdata      instruction word
//   stall           decode cannot accept; IF/ID holds
//   redirect        taken branch/jump, restart fetch at redirect_pc
//   redirect_pc     new PC (bits [1:0] ignored for addressing)
//   id_valid..id_imm16  IF/ID outputs and field slices
//   misalign_err    sticky misaligned-redirect flag (0 unless feature enabled)
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16,
    output logic        misalign_err
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] addr_next;
    logic        ack_v;
    logic        load, park, unpark, bubble;
    ifid_t       din;

    // An ack with no request outstanding (e.g. left over from before reset) is ignored.
    assign ack_v     = imem_ack & imem_req;
    assign target    = align_word(redirect_pc);
    assign addr_next = imem_addr + 32'd4;
    assign din       = '{instr: imem_rdata, pc4: addr_next};

    always_comb begin
        load   = 1'b0;
        park   = 1'b0;
        unpark = 1'b0;
        bubble = 1'b0;
        if (!redirect) begin
            case (state)
                ST_REQ: begin
                    load   = ack_v & ~stall;
                    park   = ack_v & stall;
                    bubble = ~ack_v & ~stall;
                end
                ST_HOLD:  unpark = ~stall;
                ST_DRAIN: bubble = 1'b1;
                default:  bubble = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
            case (state)
                ST_REQ: begin
                    // A pending request is never withdrawn: wait it out in DRAIN.
                    if (imem_req && !imem_ack) begin
                        state <= ST_DRAIN;
                    end else begin
                        imem_addr <= target;
                        imem_req  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ack_v) begin
                        imem_addr <= target;
                        state     <= ST_REQ;
                    end
                end
                default: begin
                    imem_addr <= target;
                    imem_req  <= 1'b1;
                    state     <= ST_REQ;
                end
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        imem_addr <= addr_next;
                        pc        <= addr_next;
                        if (stall) begin
                            imem_req <= 1'b0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        imem_req <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (ack_v) begin
                        imem_addr <= pc;
                        state     <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .park     (park),
        .unpark   (unpark),
        .bubble   (bubble),
        .flush    (redirect),
        .din      (din),
        .id_valid (id_valid),
        .id_instr (id_instr),
        .id_pc4   (id_pc4),
        .id_opcode(id_opcode),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .id_shamt (id_shamt),
        .id_funct (id_funct),
        .id_imm16 (id_imm16)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic        misalign_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_funct    (id_funct),
        .id_imm16    (id_imm16),
        .misalign_err(misalign_err)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_mis;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic stl,
                                input logic redir, input logic [31:0] rpc, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc4,
                                input logic e_mis);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = stl; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " imem_req"}, {31'h0, imem_req}, 32'h0);
        check({tag, " imem_addr"}, imem_addr, 32'h0);
        check({tag, " id_valid"}, {31'h0, id_valid}, 32'h0);
        check({tag, " id_instr"}, id_instr, 32'h0);
        check({tag, " id_pc4"}, id_pc4, 32'h0);
        check({tag, " misalign_err"}, {31'h0, misalign_err}, 32'h0);
    endtask

    initial begin
        logic [31:0] w;

        //          ack rdata          stl rd  rpc           req addr          vld instr          pc4           mis
        vecs[0]  = mk(1, 32'hBAD0_0000, 0, 0, 32'h0,        1, 32'h0000_0000, 0, 32'h0,        32'h0,        0);
        vecs[1]  = mk(1, 32'h3C01_1234, 0, 0, 32'h0,        1, 32'h0000_0004, 1, 32'h3C01_1234, 32'h0000_0004, 0);
        vecs[2]  = mk(1, 32'h3421_FFFF, 0, 0, 32'h0,        1, 32'h0000_0008, 1, 32'h3421_FFFF, 32'h0000_0008, 0);
        vecs[3]  = mk(1, 32'h2008_0005, 1, 0, 32'h0,        0, 32'h0000_000C, 1, 32'h3421_FFFF, 32'h0000_0008, 0);
        vecs[4]  = mk(0, 32'h0,         1, 0, 32'h0,        0, 32'h0000_000C, 1, 32'h3421_FFFF, 32'h0000_0008, 0);
        vecs[5]  = mk(0, 32'h0,         1, 0, 32'h0,        0, 32'h0000_000C, 1, 32'h3421_FFFF, 32'h0000_0008, 0);
        vecs[6]  = mk(0, 32'h0,         0, 0, 32'h0,        1, 32'h0000_000C, 1, 32'h2008_0005, 32'h0000_000C, 0);
        vecs[7]  = mk(0, 32'h0,         0, 0, 32'h0,        1, 32'h0000_000C, 0, 32'h0,        32'h0,        0);
        vecs[8]  = mk(1, 32'h8C43_0004, 0, 0, 32'h0,        1, 32'h0000_0010, 1, 32'h8C43_0004, 32'h0000_0010, 0);
        vecs[9]  = mk(0, 32'h0,         0, 1, 32'h0000_0100, 1, 32'h0000_0010, 0, 32'h0,        32'h0,        0);
        vecs[10] = mk(0, 32'h0,         0, 0, 32'h0,        1, 32'h0000_0010, 0, 32'h0,        32'h0,        0);
        vecs[11] = mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0,        32'h0,        0);
        vecs[12] = mk(1, 32'h2402_0007, 0, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h2402_0007, 32'h0000_0104, 0);
        vecs[13] = mk(1, 32'h1111_1111, 1, 1, 32'h0000_0200, 1, 32'h0000_0200, 0, 32'h0,        32'h0,        0);
        vecs[14] = mk(1, 32'h2222_2222, 0, 0, 32'h0,        1, 32'h0000_0204, 1, 32'h2222_2222, 32'h0000_0204, 0);
        vecs[15] = mk(1, 32'h0BAD_BAD0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,        0);
        vecs[16] = mk(1, 32'h3333_3333, 0, 0, 32'h0,        1, 32'h0000_0000, 1, 32'h3333_3333, 32'h0000_0000, 0);
        vecs[17] = mk(0, 32'h0,         0, 1, 32'h0000_0102, 1, 32'h0000_0000, 0, 32'h0,        32'h0,        1);
        vecs[18] = mk(1, 32'h0BAD_BAD1, 0, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0,        32'h0,        1);
        vecs[19] = mk(1, 32'h4444_4444, 0, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h4444_4444, 32'h0000_0104, 1);
        vecs[20] = mk(1, 32'h5555_5555, 1, 0, 32'h0,        0, 32'h0000_0108, 1, 32'h4444_4444, 32'h0000_0104, 1);
        vecs[21] = mk(0, 32'h0,         1, 1, 32'h0000_0300, 1, 32'h0000_0300, 0, 32'h0,        32'h0,        1);
        vecs[22] = mk(0, 32'h0,         0, 0, 32'h0,        1, 32'h0000_0300, 0, 32'h0,        32'h0,        1);
        vecs[23] = mk(1, 32'h6666_6666, 0, 0, 32'h0,        1, 32'h0000_0304, 1, 32'h6666_6666, 32'h0000_0304, 1);
        vecs[24] = mk(0, 32'h0,         0, 1, 32'h0000_0400, 1, 32'h0000_0304, 0, 32'h0,        32'h0,        1);
        vecs[25] = mk(0, 32'h0,         0, 1, 32'h0000_0500, 1, 32'h0000_0304, 0, 32'h0,        32'h0,        1);
        vecs[26] = mk(1, 32'h0BAD_BAD2, 0, 0, 32'h0,        1, 32'h0000_0500, 0, 32'h0,        32'h0,        1);
        vecs[27] = mk(1, 32'h7777_7777, 0, 0, 32'h0,        1, 32'h0000_0504, 1, 32'h7777_7777, 32'h0000_0504, 1);
        vecs[28] = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0504, 1, 32'h7777_7777, 32'h0000_0504, 1);
        vecs[29] = mk(1, 32'h8888_8888, 0, 0, 32'h0,        1, 32'h0000_0508, 1, 32'h8888_8888, 32'h0000_0508, 1);

        rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1 rst = 1'b1;
        #2 check_reset_values("reset");
        #9 rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            imem_ack    = vecs[i].ack;
            imem_rdata  = vecs[i].rdata;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            check($sformatf("v%0d imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d id_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d misalign_err", i), {31'h0, misalign_err},
                  {31'h0, MIS_EN & vecs[i].e_mis});
            if (vecs[i].e_valid) begin
                w = vecs[i].e_instr;
                check($sformatf("v%0d id_instr", i), id_instr, w);
                check($sformatf("v%0d id_pc4", i), id_pc4, vecs[i].e_pc4);
                check($sformatf("v%0d id_imm16", i), {16'h0, id_imm16}, {16'h0, w[15:0]});
                check($sformatf("v%0d id_opcode", i), {26'h0, id_opcode}, {26'h0, w[31:26]});
            end
            if (i == 1) begin
                check("v1 id_rs", {27'h0, id_rs}, 32'd0);
                check("v1 id_rt", {27'h0, id_rt}, 32'd1);
                check("v1 id_rd", {27'h0, id_rd}, 32'd2);
                check("v1 id_shamt", {27'h0, id_shamt}, 32'd8);
                check("v1 id_funct", {26'h0, id_funct}, 32'h34);
            end
        end

        // Asynchronous reset in the middle of an outstanding request.
        imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        #3 rst = 1'b1;
        #1 check_reset_values("mid-request reset");
        @(posedge clk);
        #1 rst = 1'b0;
        // A stale ack right after reset release must not be captured.
        imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
        @(posedge clk);
        #1;
        check("post-reset imem_req", {31'h0, imem_req}, 32'h1);
        check("post-reset imem_addr", imem_addr, 32'h0);
        check("post-reset id_valid", {31'h0, id_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("post-reset fetch id_valid", {31'h0, id_valid}, 32'h1);
        check("post-reset fetch id_instr", id_instr, 32'h9999_9999);
        check("post-reset fetch id_pc4", id_pc4, 32'h4);
        check("post-reset fetch imem_addr", imem_addr, 32'h4);
        check("post-reset misalign_err", {31'h0, misalign_err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit MIPS core: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the IF/ID pipeline register. It sits directly upstream of decode and the immediate extenders. Its `id_imm16` output is the 16-bit field that the 16-to-32 zero/sign extenders consume, and its R/I/J fields feed the register file and control unit.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request, registered.
- `imem_addr`  out  32  word-aligned read address, registered. Stable while `imem_req` is high and unacked.
- `imem_ack`  in  1  read data valid this cycle; ends the request.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_ack`=1.
- `stall`  in  1  decode cannot accept; the IF/ID register holds.
- `redirect`  in  1  branch/jump taken; restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC.
- `id_valid`  out  1  IF/ID register holds a live instruction.
- `id_instr`  out  32  raw instruction.
- `id_pc4`  out  32  address of the instruction + 4.
- `id_opcode` [31:26], `id_rs` [25:21], `id_rt` [20:16], `id_rd` [15:11], `id_shamt` [10:6], `id_funct` [5:0], `id_imm16` [15:0]  out  slices of `id_instr`, driven from the registered word.
- `misalign_err`  out  1  sticky redirect-alignment flag (see Configuration).

## Operation
FSM states:
- **REQ:** request outstanding.
- **HOLD:** one fetched word is parked in the skid buffer because `stall` was high.
- **DRAIN:** a request is outstanding at a stale address after a redirect.

Reset:
- `pc`=`RESET_PC`, state=REQ.
- `imem_req`=0, `imem_addr`=`RESET_PC`.
- `id_valid`=0, `id_instr`=0, `id_pc4`=0, skid buffer empty, `misalign_err`=0.

Transitions:
- **REQ, `imem_ack`=1, `stall`=0:** IF/ID <= {`imem_rdata`, `imem_addr`+4}; `id_valid`<=1; `imem_addr`<=`imem_addr`+4; stay REQ.
- **REQ, `imem_ack`=1, `stall`=1:** skid <= word; `imem_req`<=0; `imem_addr`<=+4; go HOLD.
- **REQ, no ack, `stall`=0:** `id_valid`<=0 (bubble).
- **REQ, no ack, `stall`=1:** IF/ID holds.
- **HOLD, `stall`=0:** skid -> IF/ID; `id_valid`<=1; `imem_req`<=1; go REQ.
- **`redirect`=1 (any state, highest priority):**
  - `id_valid`<=0; skid dropped; `pc`<=`redirect_pc`.
  - If a request is unacked, or is acked this same cycle: the request is never withdrawn. If unacked, go DRAIN and hold `imem_addr`; an ack arriving this cycle has its data discarded. Then `imem_addr`<=`redirect_pc` and go REQ.
  - From HOLD: go REQ with `imem_addr`<=`redirect_pc`.
- **DRAIN:** on `imem_ack`, discard data, `imem_addr`<=`pc`, go REQ. A second `redirect` in DRAIN overwrites `pc` only.
- **`stall` and `redirect` together:** `redirect` wins; `id_valid`<=0 even while stalled.
- **PC arithmetic:** modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- `imem_req` rises on the first rising edge after `rst` falls.
- Throughput: one instruction per cycle when memory acks every cycle.
- Latency: IF/ID and `id_*` update on the same edge that samples `imem_ack`. No combinational path from `imem_rdata` to the `id_*` outputs.
- `rst` asserted mid-request: everything returns to reset values immediately. A late `imem_ack` after reset release with no request outstanding is ignored.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: a `redirect` with `redirect_pc[1:0]`≠0 sets `misalign_err` (sticky until `rst`). Fetch then continues at `redirect_pc` with bits [1:0] forced to 00.
- Not defined: bits [1:0] are forced to 00 silently, and `misalign_err` is tied 0.

## Structure
- Shared package `mips_pkg`:
  - field-position constants (`OPCODE_MSB`/`LSB`, etc.);
  - the 32'h0000_0000 default reset vector;
  - FSM state encoding (REQ/HOLD/DRAIN, 2 bits).
- Sub-module `if_id_reg`: the IF/ID register plus one-entry skid buffer, with load/hold/clear controls and the field slicing.
- `fetch_stage` keeps the PC, the address register and the FSM.

## Test plan
- **Reset and stream:** `rst` pulse, memory acks every cycle returning 0x3C01_1234, 0x3421_FFFF → `imem_addr` 0,4,8; `id_imm16`=0x1234 then 0xFFFF; `id_pc4`=4 then 8; `id_valid` high from the first ack edge.
- **Stall with skid:** ack word 0x2008_0005 while `stall`=1 for 3 cycles → `imem_req` low during stall; the word appears on `id_instr` on the edge after `stall` falls; no word lost or duplicated.
- **Redirect while waiting:** `redirect`=1, `redirect_pc`=0x0000_0100 while a request at 0x10 is unacked and ack delayed 2 cycles → `imem_addr` holds 0x10 until ack; that data is discarded; next request at 0x100; `id_valid`=0 throughout.
- **Redirect and stall together:** `redirect`=1 and `stall`=1 on the same edge → `id_valid`=0 and fetch restarts at `redirect_pc`.
- **Wrap-around:** redirect to 0xFFFF_FFFC, ack → `id_pc4`=0, next `imem_addr`=0.
- **Alignment:** redirect to 0x0000_0102 → fetch at 0x100; `misalign_err`=1 with `FETCH_ALIGN_CHECK_EN` defined, 0 without.
